// File: rtl/universal_register.sv
// WIDTH-bit storage element with enable, synchronous clear and eight operations:
// hold, load, shift left/right, rotate left/right, count up/down.
module universal_register #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             En,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero,
    output logic             sout_l,
    output logic             sout_r
);

    localparam int unsigned   SUM_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_UP    = 3'd6,
        MODE_DOWN  = 3'd7
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_carry_nxt;
    logic [SUM_W-1:0] w_inc;
    logic [SUM_W-1:0] w_dec;
    mode_e            w_mode;

    // One extra bit on each side of the counter captures the wrap/borrow.
    assign w_inc  = {1'b0, r_q} + SUM_W'(1);
    assign w_dec  = {1'b0, r_q} - SUM_W'(1);
    assign w_mode = mode_e'(mode);

    // Next-state decode: clear beats enable, enable gates the mode.
    always_comb begin
        w_q_nxt     = r_q;
        w_carry_nxt = r_carry;
        if (clr) begin
            w_q_nxt     = '0;
            w_carry_nxt = 1'b0;
        end else if (En) begin
            case (w_mode)
                MODE_HOLD: begin
                    w_q_nxt     = r_q;
                    w_carry_nxt = 1'b0;
                end
                MODE_LOAD: begin
                    w_q_nxt     = D;
                    w_carry_nxt = 1'b0;
                end
                MODE_SHL: begin
                    w_q_nxt     = {r_q[WIDTH-2:0], sin_l};
                    w_carry_nxt = r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    w_q_nxt     = {sin_r, r_q[WIDTH-1:1]};
                    w_carry_nxt = r_q[0];
                end
                MODE_ROL: begin
                    w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_carry_nxt = r_q[WIDTH-1];
                end
                MODE_ROR: begin
                    w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
                    w_carry_nxt = r_q[0];
                end
                MODE_UP: begin
                    w_q_nxt     = w_inc[WIDTH-1:0];
                    w_carry_nxt = w_inc[WIDTH];
                end
                MODE_DOWN: begin
                    w_q_nxt     = w_dec[WIDTH-1:0];
                    w_carry_nxt = w_dec[WIDTH];
                end
                default: begin
                    w_q_nxt     = r_q;
                    w_carry_nxt = r_carry;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= RST_Q;
            r_carry <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign q      = r_q;
    assign carry  = r_carry;
    assign zero   = (r_q == '0);
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register with enable, synchronous clear and an 8-mode operation select.
- Modes: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, and up/down count.
- Used as the generic storage, shift and count element in later lab datapaths. It replaces ad-hoc per-bit flip-flop instances.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q on asynchronous reset; truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces reset state immediately.
- En  input  1  enable. 1 = mode executes at the edge; 0 = q and carry hold.
- clr  input  1  synchronous clear. Priority over En and mode.
- mode  input  3  operation select (see Behaviour).
- D  input  WIDTH  parallel load data.
- sin_l  input  1  serial input shifted into bit 0 on shift-left.
- sin_r  input  1  serial input shifted into bit WIDTH-1 on shift-right.
- q  output  WIDTH  register contents.
- carry  output  1  registered shifted-out bit or count wrap flag.
- zero  output  1  combinational, 1 when q == 0.
- sout_l  output  1  combinational copy of q[WIDTH-1].
- sout_r  output  1  combinational copy of q[0].

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): q=RESET_VAL, carry=0. While reset is low, clk edges have no effect. Release is synchronous-safe; the first active edge after release acts normally.
- Priority at each rising edge (reset high): clr, then En, then mode.
- clr=1: q=0, carry=0, regardless of En and mode.
- En=0 (and clr=0): q and carry hold.
- En=1, mode decode:
  - 000 hold: q holds, carry=0.
  - 001 load: q=D, carry=0.
  - 010 shift left: q={q[WIDTH-2:0], sin_l}, carry=old q[WIDTH-1].
  - 011 shift right: q={sin_r, q[WIDTH-1:1]}, carry=old q[0].
  - 100 rotate left: q={q[WIDTH-2:0], q[WIDTH-1]}, carry=old q[WIDTH-1].
  - 101 rotate right: q={q[0], q[WIDTH-1:1]}, carry=old q[0].
  - 110 count up: q=q+1 modulo 2^WIDTH; carry=1 only when old q was all ones (wrap to 0), else 0.
  - 111 count down: q=q-1 modulo 2^WIDTH; carry=1 only when old q was 0 (wrap to all ones), else 0.
- Latency: q and carry reflect an operation one edge after it is sampled. zero, sout_l and sout_r follow q combinationally, with zero latency relative to q.
- Carry is a per-operation flag: it is overwritten on every enabled or cleared edge and is not sticky.
- Mode change takes effect at the very next enabled edge, with no pipeline bubble.
- Reset asserted mid-operation (e.g. mid count or shift sequence): q=RESET_VAL, carry=0 immediately. No partial update may survive.
- All arithmetic is unsigned WIDTH-bit with no saturation.

Test Plan (WIDTH=8, RESET_VAL=8'hA5 unless noted):
- Reset: assert reset=0 between edges -> q=8'hA5, carry=0 before the next clk edge. Toggle clk with reset=0 -> q stays 8'hA5.
- Load, enable and clear: En=1, mode=001, D=8'h3C, one edge -> q=8'h3C, zero=0. En=0, D=8'hFF, three edges -> q stays 8'h3C. clr=1 with En=0 -> q=8'h00, zero=1, carry=0.
- Shifts: from q=8'h81, mode=010 with sin_l=0 -> q=8'h02, carry=1. Then mode=011 with sin_r=1 -> q=8'h81, carry=0. Then rotate left -> q=8'h03, carry=1. Then rotate right -> q=8'h81, carry=1.
- Count wrap up: load 8'hFE, mode=110, two edges -> q=8'hFF with carry=0, then q=8'h00 with carry=1 and zero=1. One more edge -> q=8'h01, carry=0.
- Count wrap down: load 8'h01, mode=111, two edges -> q=8'h00 with carry=0 and zero=1, then q=8'hFF with carry=1. Mode=000 -> q=8'hFF, carry=0.
- Reset mid-count, plus parameter sweep: counting up from 8'h10, pulse reset low for half a cycle -> q=8'hA5 immediately, and counting resumes from 8'hA5 next edge (8'hA6). Repeat the shift, rotate and count cases with WIDTH=4, RESET_VAL=0: 4'hF up -> 4'h0 with carry=1.
